cordic_engine: RTL

CORDIC_ENGINE -- requirements
Module: cordic_engine

---
 rtl/cordic_pkg.sv | 35 +++
 rtl/cordic_atan_rom.sv | 56 +++++
 rtl/cordic_engine.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC engine: FSM state codes, mode encoding, angle constants.
// Latency: n/a (constants and a pure rounding helper).
// Backpressure: n/a.
package cordic_pkg;

    // FSM state codes, kept as plain constants so legacy code can compare against them
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ROTATE = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // Operating mode
    localparam logic MODE_ROT = 1'b0;   // drive z to zero
    localparam logic MODE_VEC = 1'b1;   // drive y to zero

    // Q2.14 reference constants (default width)
    localparam logic signed [15:0] HALF_PI_Q14 = 16'sd25736;  // pi/2
    localparam logic signed [15:0] KINV_Q14    = 16'sd9949;   // 1/K = 0.60725

    // High-precision pi/2 in Q2.30, rounded per build width with q30_round()
    localparam logic [31:0] HALF_PI_Q30 = 32'd1686629713;

    // Round a non-negative Q2.30 value to 'frac' fractional bits (frac <= 30).
    // Inputs are truncated Q2.30 constants, so a single round-half-up here
    // gives the same result as rounding the exact value.
    function automatic logic [31:0] q30_round(input logic [31:0] v, input int frac);
        logic [32:0] sum;
        if (frac >= 30) begin
            return v;
        end
        sum = {1'b0, v} + (33'd1 << (29 - frac));
        return 32'(sum >> (30 - frac));
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent table: atan(2^-index) rounded to nearest in Q2.(WIDTH-2).
// Latency: combinational.
// Backpressure: n/a.
// Ports: index (iteration number, 0..ITER), angle (signed Q2.(WIDTH-2), 0 past the table).
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 14
) (
    input  logic [$clog2(ITER+1)-1:0] index,
    output logic signed [WIDTH-1:0]   angle
);

    logic [31:0] raw;

    // Truncated Q2.30 values; for i >= 10 atan(2^-i) sits just below 2^-i.
    always_comb begin
        raw = 32'd0;
        case (int'(index))
            0:  raw = 32'h3243F6A8;
            1:  raw = 32'h1DAC6705;
            2:  raw = 32'h0FADBAFC;
            3:  raw = 32'h07F56EA6;
            4:  raw = 32'h03FEAB76;
            5:  raw = 32'h01FFD55B;
            6:  raw = 32'h00FFFAAA;
            7:  raw = 32'h007FFF55;
            8:  raw = 32'h003FFFEA;
            9:  raw = 32'h001FFFFD;
            10: raw = 32'h000FFFFF;
            11: raw = 32'h0007FFFF;
            12: raw = 32'h0003FFFF;
            13: raw = 32'h0001FFFF;
            14: raw = 32'h0000FFFF;
            15: raw = 32'h00007FFF;
            16: raw = 32'h00003FFF;
            17: raw = 32'h00001FFF;
            18: raw = 32'h00000FFF;
            19: raw = 32'h000007FF;
            20: raw = 32'h000003FF;
            21: raw = 32'h000001FF;
            22: raw = 32'h000000FF;
            23: raw = 32'h0000007F;
            24: raw = 32'h0000003F;
            25: raw = 32'h0000001F;
            26: raw = 32'h0000000F;
            27: raw = 32'h00000007;
            28: raw = 32'h00000003;
            29: raw = 32'h00000001;
            default: raw = 32'd0;
        endcase
        angle = WIDTH'(q30_round(raw, WIDTH - 2));
    end

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine (rotation / vectoring), no gain compensation, saturated outputs.
// Latency: start accepted at edge N -> done high in the cycle after edge N+ITER+1.
// Backpressure: none; start is ignored while busy (ROTATE/DONE), outputs held until overwritten.
// Ports: clock, reset (sync, active-high), start, mode (0 rot / 1 vec), x_in/y_in/z_in,
//        busy, done (1-cycle pulse), x_out/y_out/z_out (registered).
// Option: define CORDIC_QUADRANT_EXT_EN for a +/-pi/2 pre-rotation at load (full input range).
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITER  = 14
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out
);

    localparam int IW = $clog2(ITER + 1);
    localparam int XW = WIDTH + 2;   // two guard bits absorb gain K and the sqrt(2) corner

    state_t                 state;
    logic [IW-1:0]          i;
    logic                   mode_r;
    logic signed [XW-1:0]   x, y, z;
    logic signed [XW-1:0]   x_ld, y_ld, z_ld;
    logic signed [XW-1:0]   x_nx, y_nx, z_nx;
    logic signed [WIDTH-1:0] atan_i;
    logic                   d_pos;

    cordic_atan_rom #(.WIDTH(WIDTH), .ITER(ITER)) u_rom (
        .index (i),
        .angle (atan_i)
    );

    // Operand load, optionally folded into the +/-pi/2 half plane the iterations can reach
`ifdef CORDIC_QUADRANT_EXT_EN
    localparam logic signed [XW-1:0] HALF_PI = XW'(q30_round(HALF_PI_Q30, WIDTH - 2));
`endif
    always_comb begin
        x_ld = XW'(x_in);
        y_ld = XW'(y_in);
        z_ld = XW'(z_in);
`ifdef CORDIC_QUADRANT_EXT_EN
        if (mode == MODE_ROT) begin
            if (XW'(z_in) > HALF_PI) begin
                x_ld = -XW'(y_in);
                y_ld = XW'(x_in);
                z_ld = XW'(z_in) - HALF_PI;
            end else if (XW'(z_in) < -HALF_PI) begin
                x_ld = XW'(y_in);
                y_ld = -XW'(x_in);
                z_ld = XW'(z_in) + HALF_PI;
            end
        end else if (x_in < 0) begin
            // Turn the vector back towards +x and account for it in the angle accumulator
            if (y_in >= 0) begin
                x_ld = XW'(y_in);
                y_ld = -XW'(x_in);
                z_ld = XW'(z_in) + HALF_PI;
            end else begin
                x_ld = -XW'(y_in);
                y_ld = XW'(x_in);
                z_ld = XW'(z_in) - HALF_PI;
            end
        end
`endif
    end

    // One micro-rotation; d_pos means d = +1 (zero counts as positive)
    always_comb begin
        d_pos = (mode_r == MODE_ROT) ? ~z[XW-1] : y[XW-1];
        x_nx  = d_pos ? x - (y >>> i) : x + (y >>> i);
        y_nx  = d_pos ? y + (x >>> i) : y - (x >>> i);
        z_nx  = d_pos ? z - XW'(atan_i) : z + XW'(atan_i);
    end

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
        if (&v[XW-1:WIDTH-1] || ~|v[XW-1:WIDTH-1]) begin
            return v[WIDTH-1:0];
        end
        return v[XW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    // ROTATE runs ITER iterations (i = 0..ITER-1) and spends the i == ITER cycle
    // registering the saturated results before DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            i      <= '0;
            mode_r <= MODE_ROT;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            x_out  <= '0;
            y_out  <= '0;
            z_out  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x      <= x_ld;
                        y      <= y_ld;
                        z      <= z_ld;
                        mode_r <= mode;
                        i      <= '0;
                        state  <= ST_ROTATE;
                    end
                end
                ST_ROTATE: begin
                    if (i == IW'(ITER)) begin
                        x_out <= sat(x);
                        y_out <= sat(y);
                        z_out <= sat(z);
                        state <= ST_DONE;
                    end else begin
                        x <= x_nx;
                        y <= y_nx;
                        z <= z_nx;
                        i <= i + IW'(1);
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule
